// File: rtl/product_accumulator.sv
// product_accumulator
// Sits directly behind the 8x8 multiplier. It accumulates the 16-bit product
// stream into a dot-product sum and presents the sum, the term count and a
// sticky overflow flag until the consumer takes them.
// Optional feature macro: SATURATE_EN
//   defined   -> on overflow the sum clamps to all-ones for the rest of the vector
//   undefined -> the sum wraps modulo 2^ACC_W
// The overflow flag behaves the same way in both builds.
module product_accumulator #(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 255,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      p,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] MaxTermsC = CNT_W'(MAX_TERMS);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] termCnt_q, termCnt_d;
  logic             ovf_q, ovf_d;
  logic             outValid_q;
  logic             close_d;
  logic [ACC_W:0]   sum;

  // Next values for a product transfer: the extra sum bit is the overflow carry.
  always_comb begin
    sum       = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, p};
    ovf_d     = ovf_q | sum[ACC_W];
`ifdef SATURATE_EN
    // Once a carry has been seen in this vector the sum stays pinned at its maximum.
    acc_d     = ovf_d ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_d     = sum[ACC_W-1:0];
`endif
    termCnt_d = termCnt_q + 1'b1;
    close_d   = in_last || (termCnt_d == MaxTermsC);
  end

  // Two-state controller: accumulate products, then hold the result for the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      termCnt_q  <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q     <= acc_d;
            termCnt_q <= termCnt_d;
            ovf_q     <= ovf_d;
            if (close_d) begin
              state_q    <= HOLD;
              outValid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= ACCUM;
            outValid_q <= 1'b0;
            acc_q      <= '0;
            termCnt_q  <= '0;
            ovf_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= ACCUM;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready is dropped immediately while reset is asserted, not one cycle later.
  assign in_ready  = (state_q == ACCUM) && !reset;
  assign out_valid = outValid_q;
  assign acc_out   = acc_q;
  assign term_cnt  = termCnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator. A second instance with a
// 17-bit accumulator exercises the overflow path; its expected sum follows
// the SATURATE_EN build option.
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic [15:0] p;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic [23:0] acc_out;
  logic [7:0]  term_cnt;
  logic        ovf;
  logic        out_valid;

  logic        in_ready17;
  logic [16:0] acc_out17;
  logic [7:0]  term_cnt17;
  logic        ovf17;
  logic        out_valid17;

  int total;
  int bad;

  product_accumulator dut (
    .clk(clk), .reset(reset), .p(p), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(17)) dut17 (
    .clk(clk), .reset(reset), .p(p), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready17), .acc_out(acc_out17), .term_cnt(term_cnt17), .ovf(ovf17),
    .out_valid(out_valid17), .out_ready(out_ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one product for exactly one rising edge; called and returns at a falling edge.
  task applyStimulus(input logic [15:0] pv, input logic lastv);
    p        = pv;
    in_valid = 1'b1;
    in_last  = lastv;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Accepts the held result with a one-cycle out_ready pulse.
  task drainResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (acc_out !== 24'd0) begin bad++; $display("FAIL reset_acc got=%0d want=0", acc_out); end
    total++; if (term_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", term_cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task test_basic();
    out_ready = 1'b1;
    applyStimulus(16'd3, 1'b0);
    applyStimulus(16'd5, 1'b0);
    applyStimulus(16'd7, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0b want=1", out_valid); end
    total++; if (acc_out !== 24'd15) begin bad++; $display("FAIL basic_acc got=%0d want=15", acc_out); end
    total++; if (term_cnt !== 8'd3) begin bad++; $display("FAIL basic_cnt got=%0d want=3", term_cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b want=0", ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_in_ready got=%0b want=0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%0b want=1", in_ready); end
    total++; if (acc_out !== 24'd0) begin bad++; $display("FAIL basic_acc_cleared got=%0d want=0", acc_out); end
  endtask

  task test_forced_close();
    out_ready = 1'b0;
    for (int i = 0; i < 254; i++) applyStimulus(16'd65025, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL forced_early_close got=%0b want=0", out_valid); end
    total++; if (term_cnt !== 8'd254) begin bad++; $display("FAIL forced_cnt254 got=%0d want=254", term_cnt); end
    applyStimulus(16'd65025, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL forced_out_valid got=%0b want=1", out_valid); end
    total++; if (acc_out !== 24'd16581375) begin bad++; $display("FAIL forced_acc got=%0d want=16581375", acc_out); end
    total++; if (term_cnt !== 8'd255) begin bad++; $display("FAIL forced_cnt got=%0d want=255", term_cnt); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL forced_ovf got=%0b want=0", ovf); end
    drainResult();
  endtask

  task test_stall();
    out_ready = 1'b0;
    applyStimulus(16'd9, 1'b1);
    p        = 16'd4;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || acc_out !== 24'd9 || term_cnt !== 8'd1 || in_ready !== 1'b0)
        begin bad++; $display("FAIL stall_hold cyc=%0d got v=%0b acc=%0d cnt=%0d rdy=%0b want v=1 acc=9 cnt=1 rdy=0",
                              i, out_valid, acc_out, term_cnt, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || acc_out !== 24'd0) begin bad++;
      $display("FAIL stall_release got v=%0b acc=%0d want v=0 acc=0", out_valid, acc_out); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (out_valid !== 1'b1 || acc_out !== 24'd4 || term_cnt !== 8'd1) begin bad++;
      $display("FAIL stall_next_vec got v=%0b acc=%0d cnt=%0d want v=1 acc=4 cnt=1", out_valid, acc_out, term_cnt); end
    drainResult();
  endtask

  task test_overflow();
    logic [16:0] expAcc;
`ifdef SATURATE_EN
    expAcc = 17'd131071;
`else
    expAcc = 17'd64003;
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    applyStimulus(16'd65025, 1'b0);
    applyStimulus(16'd65025, 1'b0);
    total++; if (ovf17 !== 1'b0 || acc_out17 !== 17'd130050) begin bad++;
      $display("FAIL ovf_pre got ovf=%0b acc=%0d want ovf=0 acc=130050", ovf17, acc_out17); end
    applyStimulus(16'd65025, 1'b1);
    total++; if (acc_out17 !== expAcc) begin bad++; $display("FAIL ovf_acc got=%0d want=%0d", acc_out17, expAcc); end
    total++; if (ovf17 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf17); end
    total++; if (term_cnt17 !== 8'd3) begin bad++; $display("FAIL ovf_cnt got=%0d want=3", term_cnt17); end
    total++; if (acc_out !== 24'd195075 || ovf !== 1'b0) begin bad++;
      $display("FAIL ovf_wide got acc=%0d ovf=%0b want acc=195075 ovf=0", acc_out, ovf); end
    drainResult();
    applyStimulus(16'd5, 1'b1);
    total++; if (ovf17 !== 1'b0 || acc_out17 !== 17'd5) begin bad++;
      $display("FAIL ovf_next_vec got ovf=%0b acc=%0d want ovf=0 acc=5", ovf17, acc_out17); end
    drainResult();
  endtask

  task test_reset_mid();
    out_ready = 1'b0;
    applyStimulus(16'd100, 1'b0);
    applyStimulus(16'd200, 1'b0);
    total++; if (acc_out !== 24'd300) begin bad++; $display("FAIL mid_partial got=%0d want=300", acc_out); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset got=%0b want=0", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || acc_out !== 24'd0 || term_cnt !== 8'd0 || in_ready !== 1'b0) begin bad++;
      $display("FAIL mid_cleared got v=%0b acc=%0d cnt=%0d rdy=%0b want 0/0/0/0", out_valid, acc_out, term_cnt, in_ready); end
    reset = 1'b0;
    applyStimulus(16'd10, 1'b1);
    total++; if (out_valid !== 1'b1 || acc_out !== 24'd10 || term_cnt !== 8'd1) begin bad++;
      $display("FAIL mid_after got v=%0b acc=%0d cnt=%0d want v=1 acc=10 cnt=1", out_valid, acc_out, term_cnt); end
    drainResult();
  endtask

  task test_zero_and_idle();
    applyStimulus(16'd0, 1'b1);
    total++; if (out_valid !== 1'b1 || acc_out !== 24'd0 || term_cnt !== 8'd1 || ovf !== 1'b0) begin bad++;
      $display("FAIL zero_term got v=%0b acc=%0d cnt=%0d ovf=%0b want v=1 acc=0 cnt=1 ovf=0", out_valid, acc_out, term_cnt, ovf); end
    drainResult();
    in_valid  = 1'b0;
    in_last   = 1'b1;
    p         = 16'd77;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0 || acc_out !== 24'd0 || term_cnt !== 8'd0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL idle_last got v=%0b acc=%0d cnt=%0d rdy=%0b want v=0 acc=0 cnt=0 rdy=1", out_valid, acc_out, term_cnt, in_ready); end
    in_last   = 1'b0;
    out_ready = 1'b0;
    applyStimulus(16'd6, 1'b0);
    applyStimulus(16'd8, 1'b1);
    total++; if (acc_out !== 24'd14 || term_cnt !== 8'd2) begin bad++;
      $display("FAIL idle_then_vec got acc=%0d cnt=%0d want acc=14 cnt=2", acc_out, term_cnt); end
    drainResult();
  endtask

  // Runs every scenario in order and prints the single summary line.
  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    p         = 16'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_forced_close();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_zero_and_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
